// File: rtl/main_memory_if.sv
// Request/response bus between a cache-side requester (master) and main_memory (slave).
// One request per handshake; read data returns on a one-cycle response strobe.
interface main_memory_if #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned OFFSET_BITS    = 6,
  parameter int unsigned CACHELINE_BITS = 512
);
  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic                             mem_req_rw;
  logic [ADDR_BITS-OFFSET_BITS-1:0] mem_req_addr;
  logic [CACHELINE_BITS-1:0]        mem_req_data;
  logic                             mem_resp_valid;
  logic [CACHELINE_BITS-1:0]        mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_rw,
    output mem_req_addr,
    output mem_req_data,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_rw,
    input  mem_req_addr,
    input  mem_req_data,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/main_memory.sv
// Fixed-latency cacheline main memory: IDLE/BUSY/RESP FSM, one request at a time.
// Optional MAIN_MEMORY_STATS_EN adds 32-bit accepted read/write counters.
module main_memory #(
  parameter int unsigned MEM_LATENCY    = 4,
  parameter int unsigned MEM_DEPTH_BITS = 8,
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned OFFSET_BITS    = 6,
  parameter int unsigned CACHELINE_BITS = 512
) (
  input  logic                clk,
  input  logic                reset_n,
  main_memory_if.slave        mem_if
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
`endif
);

  localparam int unsigned STORAGE_DEPTH = 1 << MEM_DEPTH_BITS;
  // Reads spend one cycle fewer in BUSY because RESP itself is the last latency cycle.
  localparam logic [7:0] WR_LOAD = 8'(MEM_LATENCY - 1);
  localparam logic [7:0] RD_LOAD = (MEM_LATENCY > 1) ? 8'(MEM_LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic                        is_read_q, is_read_d;
  logic                        ready_q, ready_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [CACHELINE_BITS-1:0]   resp_data_q, resp_data_d;
  logic                        accept_s;
  logic                        wr_en_s;
  logic [MEM_DEPTH_BITS-1:0]   index_s;
  logic                        unused_addr_s;

  // Storage is not touched by reset, so it carries its power-up zero content.
  logic [CACHELINE_BITS-1:0]   storage_q [STORAGE_DEPTH] = '{default: {CACHELINE_BITS{1'b0}}};

  assign index_s       = mem_if.mem_req_addr[MEM_DEPTH_BITS-1:0];
  assign unused_addr_s = ^{1'b0, mem_if.mem_req_addr};

  assign mem_if.mem_req_ready  = ready_q;
  assign mem_if.mem_resp_valid = resp_valid_q;
  assign mem_if.mem_resp_data  = resp_data_q;

  // Handshake qualification, next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    resp_data_d = resp_data_q;
    wr_en_s   = 1'b0;
    accept_s  = reset_n & mem_if.mem_req_valid & ready_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (mem_if.mem_req_rw) begin
            wr_en_s   = 1'b1;
            is_read_d = 1'b0;
            cnt_d     = WR_LOAD;
            state_d   = BUSY;
          end else begin
            is_read_d   = 1'b1;
            resp_data_d = storage_q[index_s];
            cnt_d       = RD_LOAD;
            if (MEM_LATENCY == 32'd1) begin
              state_d = RESP;
            end else begin
              state_d = BUSY;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = is_read_q ? RESP : IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      is_read_q    <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= {CACHELINE_BITS{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_read_q    <= is_read_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Cacheline storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      storage_q[index_s] <= mem_if.mem_req_data;
    end
  end

`ifdef MAIN_MEMORY_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Accepted-request counters, wrapping naturally at 32 bits.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept_s && !mem_if.mem_req_rw) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end else if (accept_s && mem_if.mem_req_rw) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory (MEM_LATENCY=4, MEM_DEPTH_BITS=8, 512-bit lines).
module tb_main_memory;
  localparam int unsigned L  = 4;
  localparam int unsigned CB = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  main_memory_if #(.ADDR_BITS(32), .OFFSET_BITS(6), .CACHELINE_BITS(CB)) bus ();

`ifdef MAIN_MEMORY_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  main_memory #(
    .MEM_LATENCY(L),
    .MEM_DEPTH_BITS(8),
    .ADDR_BITS(32),
    .OFFSET_BITS(6),
    .CACHELINE_BITS(CB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_if(bus)
`ifdef MAIN_MEMORY_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [CB-1:0] act, input logic [CB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return at the sample point of the first cycle after acceptance.
  task automatic issue(input logic rw, input logic [25:0] addr, input logic [CB-1:0] data);
    int waited = 0;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = rw;
    bus.mem_req_addr  = addr;
    bus.mem_req_data  = data;
    while (!bus.mem_req_ready && waited < 50) begin
      tick();
      waited++;
    end
    check_eq("accept_timeout", (waited < 50), 1'b1);
    tick();
    bus.mem_req_valid = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [25:0] addr, input logic [CB-1:0] exp);
    issue(1'b0, addr, {CB{1'b0}});
    for (int k = 1; k < L; k++) begin
      check_eq({tag, "_early_valid"}, bus.mem_resp_valid, 1'b0);
      check_eq({tag, "_busy_ready"}, bus.mem_req_ready, 1'b0);
      tick();
    end
    check_eq({tag, "_valid"}, bus.mem_resp_valid, 1'b1);
    check_eq({tag, "_data"}, bus.mem_resp_data, exp);
    check_eq({tag, "_resp_ready"}, bus.mem_req_ready, 1'b0);
    tick();
    check_eq({tag, "_valid_drop"}, bus.mem_resp_valid, 1'b0);
    check_eq({tag, "_ready_back"}, bus.mem_req_ready, 1'b1);
    check_eq({tag, "_data_hold"}, bus.mem_resp_data, exp);
  endtask

  task automatic do_write(input string tag, input logic [25:0] addr, input logic [CB-1:0] data);
    issue(1'b1, addr, data);
    for (int k = 1; k <= L; k++) begin
      check_eq({tag, "_busy_ready"}, bus.mem_req_ready, 1'b0);
      check_eq({tag, "_no_resp"}, bus.mem_resp_valid, 1'b0);
      tick();
    end
    check_eq({tag, "_ready_back"}, bus.mem_req_ready, 1'b1);
  endtask

  initial begin
    int acc_cycle[$];
    int resp_seen;
    logic flip;
    logic [CB-1:0] pat_a5, pat_11, pat_22, pat_3c, pat_5a, pat_ff;

    pat_a5 = {64{8'hA5}};
    pat_11 = {64{8'h11}};
    pat_22 = {64{8'h22}};
    pat_3c = {64{8'h3C}};
    pat_5a = {64{8'h5A}};
    pat_ff = {64{8'hFF}};

    bus.mem_req_valid = 1'b0;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = 26'd0;
    bus.mem_req_data  = {CB{1'b0}};

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_resp_valid", bus.mem_resp_valid, 1'b0);
    check_eq("rst_resp_data", bus.mem_resp_data, {CB{1'b0}});
    reset_n = 1'b1;
    tick();
    check_eq("rst_ready", bus.mem_req_ready, 1'b1);

    // Never-written line reads zero, response exactly L cycles after acceptance
    do_read("rd05", 26'h05, {CB{1'b0}});

    // Write then read back
    do_write("wr12", 26'h12, pat_a5);
    do_read("rd12", 26'h12, pat_a5);

    // Aliasing on the upper address bits
    do_write("wr003", 26'h003, pat_11);
    do_write("wr103", 26'h103, pat_22);
    do_read("rd003", 26'h003, pat_22);

    // Valid held high with alternating rw: one acceptance every L+1 cycles
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b1;
    bus.mem_req_addr  = 26'h40;
    bus.mem_req_data  = pat_3c;
    for (int i = 0; i < 20; i++) begin
      flip = 1'b0;
      if (bus.mem_resp_valid) begin
        check_eq("hold_resp_data", bus.mem_resp_data, pat_3c);
      end
      if (bus.mem_req_ready) begin
        acc_cycle.push_back(i);
        flip = 1'b1;
      end
      tick();
      if (flip) bus.mem_req_rw = ~bus.mem_req_rw;
    end
    bus.mem_req_valid = 1'b0;
    check_eq("hold_accept_count", acc_cycle.size(), 4);
    for (int j = 0; j < acc_cycle.size(); j++) begin
      check_eq("hold_accept_cycle", acc_cycle[j], 5 * j);
    end
    tick();

    // Reset drops an in-flight read; a request held during reset is ignored
    do_write("wr07", 26'h07, pat_5a);
    issue(1'b0, 26'h07, {CB{1'b0}});
    tick();
    resp_seen = 0;
    reset_n = 1'b0;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b1;
    bus.mem_req_addr  = 26'h12;
    bus.mem_req_data  = pat_ff;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_resp_valid) resp_seen++;
    end
    reset_n = 1'b1;
    bus.mem_req_valid = 1'b0;
    for (int i = 0; i < L + 4; i++) begin
      tick();
      if (bus.mem_resp_valid) resp_seen++;
    end
    check_eq("rst_drop_resp", resp_seen, 0);
    check_eq("rst_after_ready", bus.mem_req_ready, 1'b1);
    do_read("rd07_after_rst", 26'h07, pat_5a);
    do_read("rd12_after_rst", 26'h12, pat_a5);

`ifdef MAIN_MEMORY_STATS_EN
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("stats_rd_reset", rd_count, 32'd0);
    check_eq("stats_wr_reset", wr_count, 32'd0);
    do_read("st_rd0", 26'h05, {CB{1'b0}});
    do_write("st_wr0", 26'h20, pat_11);
    do_read("st_rd1", 26'h20, pat_11);
    do_write("st_wr1", 26'h21, pat_22);
    do_read("st_rd2", 26'h21, pat_22);
    check_eq("stats_rd", rd_count, 32'd3);
    check_eq("stats_wr", wr_count, 32'd2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("stats_rd_clr", rd_count, 32'd0);
    check_eq("stats_wr_clr", wr_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles from request acceptance to read response; legal range 1..255.
REQ-002 Parameter MEM_DEPTH_BITS, default 8: storage holds 2**MEM_DEPTH_BITS cachelines.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset_n  input  1  reset is synchronous and active-low.
REQ-005 mem_req_valid  input  1  requester holds request valid.
REQ-006 mem_req_ready  output  1  block can accept a request this cycle.
REQ-007 mem_req_rw  input  1  0 read, 1 write.
REQ-008 mem_req_addr  input  ADDR_BITS-OFFSET_BITS  cacheline address.
REQ-009 mem_req_data  input  CACHELINE_BITS  write data.
REQ-010 mem_resp_valid  output  1  one-cycle read-response strobe.
REQ-011 mem_resp_data  output  CACHELINE_BITS  read data, meaningful only while mem_resp_valid=1.

Function
REQ-012 FSM states IDLE, BUSY, RESP; mem_req_ready SHALL be 1 only in IDLE.
REQ-013 Handshake = mem_req_valid & mem_req_ready at a posedge; no request accepted otherwise; requester may hold valid indefinitely with no side effect.
REQ-014 Storage index = mem_req_addr[MEM_DEPTH_BITS-1:0]; upper address bits ignored (aliasing is legal).
REQ-015 Write accepted at edge T: storage[index] <= mem_req_data at that edge; IDLE->BUSY; counter loaded with MEM_LATENCY-1.
REQ-016 Read accepted at edge T: storage[index] captured into response register at that edge; IDLE->BUSY (MEM_LATENCY>1) or IDLE->RESP (MEM_LATENCY=1).
REQ-017 BUSY: counter decrements each cycle; at counter=0, read -> RESP, write -> IDLE.
REQ-018 Read timing: mem_resp_valid=1 for exactly the single cycle MEM_LATENCY cycles after acceptance; RESP->IDLE unconditionally next edge (no response backpressure).
REQ-019 Write timing: no response; mem_req_ready low for MEM_LATENCY cycles after acceptance, high again in the following cycle.
REQ-020 Read timing: mem_req_ready low from acceptance through the RESP cycle; high the cycle after RESP.
REQ-021 Read to an index written earlier SHALL return the latest written data; back-to-back requests separated only by the busy window are legal.
REQ-022 Never-written locations read as all-zero (storage zero-initialised at time zero).
REQ-023 mem_resp_data holds last response value outside RESP.

Reset
REQ-024 reset_n=0 at a posedge: state IDLE, counter 0, mem_resp_valid 0, mem_resp_data 0, mem_req_ready 1 from the cycle after reset deasserts.
REQ-025 Reset mid-operation drops any in-flight read (no response ever issued); writes already committed remain in storage; storage is never cleared by reset.
REQ-026 Request presented while reset_n=0 SHALL NOT be accepted.

Configuration
REQ-027 Macro MAIN_MEMORY_STATS_EN: when defined, adds outputs rd_count and wr_count (32 bits each), incremented on every accepted read/write, reset to 0, wrapping 0xFFFFFFFF->0; when undefined, ports and counters absent, behaviour otherwise identical.

Verification
REQ-028 Reset then read addr 0x05 (MEM_LATENCY=4) -> mem_resp_valid exactly 4 cycles after acceptance, data all-zero, ready high next cycle.
REQ-029 Write addr 0x12 data 0xA5..A5, then read 0x12 -> ready low 4 cycles after write; read returns 0xA5..A5.
REQ-030 Write 0x003 data 0x11..11, write 0x103 data 0x22..22 (MEM_DEPTH_BITS=8), read 0x003 -> returns 0x22..22 (alias).
REQ-031 Hold mem_req_valid high continuously with alternating rw -> one acceptance per (MEM_LATENCY+1)-cycle window for reads, MEM_LATENCY+1 for writes; no duplicate acceptance.
REQ-032 Read accepted, reset_n pulsed low 2 cycles later -> no mem_resp_valid ever; block IDLE and ready after reset; earlier writes still readable.
REQ-033 With MAIN_MEMORY_STATS_EN, 3 reads + 2 writes -> rd_count=3, wr_count=2; after reset both 0.
